// File: rtl/spi_reg_pkg.sv
// Shared types and helpers for the SPI register sequencer.
//   state_t    : sequencer FSM states
//   CMD_*      : command byte field positions
//   addr_wrap  : register address increment, modulo the implemented register count
package spi_reg_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, READ, ERR} state_t;

  localparam int CMD_RW_BIT   = 7;
  localparam int CMD_ADDR_MSB = 6;

  function automatic int unsigned addr_wrap(input int unsigned a, input int unsigned n);
    return (a + 1 >= n) ? 32'd0 : a + 1;
  endfunction

endpackage

// File: rtl/spi_reg_sequencer_poci.sv
// POCI shift register: parallel load, shift-left with zero fill, MSB serial out.
//   i_sclk, i_rstn : clock, async active-low reset
//   i_clr          : synchronous clear (frame end), highest priority
//   i_load, i_din  : parallel load
//   i_shift        : shift left one bit
//   o_sout         : serial output (MSB)
module poci_shift_reg #(
  parameter int W = 8
) (
  input  logic         i_sclk,
  input  logic         i_rstn,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic         i_shift,
  input  logic [W-1:0] i_din,
  output logic         o_sout
);

  logic [W-1:0] r_sr;

  always_ff @(posedge i_sclk or negedge i_rstn) begin
    if (!i_rstn)      r_sr <= '0;
    else if (i_clr)   r_sr <= '0;
    else if (i_load)  r_sr <= i_din;
    else if (i_shift) r_sr <= {r_sr[W-2:0], 1'b0};
  end

  assign o_sout = r_sr[W-1];

endmodule

// File: rtl/spi_reg_sequencer.sv
// SPI register transaction sequencer. First byte of a frame is a command
// (bit7 R/W, bits[6:0] start address); following bytes are write data or
// dummy bytes clocking out auto-incrementing reads on POCI.
//   sclk, rstn             : clock, async active-low reset
//   byte_valid, byte_data  : assembled byte from the serial front end
//   frame_end              : clock-stop pulse, terminates the frame
//   rd_addr, rd_data       : register bank read port (combinational data)
//   wr_en, wr_addr, wr_data: register bank write strobe
//   poci                   : serial read data, MSB first
//   busy, err              : not-idle flag, sticky per-frame error
module spi_reg_sequencer
  import spi_reg_pkg::*;
#(
  parameter int                     DATA_W   = 8,
  parameter int                     ADDR_W   = 7,
  parameter int unsigned            NUM_REGS = 32,
  parameter logic [NUM_REGS-1:0]    RO_MASK  = 32'h0000_0001
) (
  input  logic              sclk,
  input  logic              rstn,
  input  logic              byte_valid,
  input  logic [DATA_W-1:0] byte_data,
  input  logic              frame_end,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              poci,
  output logic              busy,
  output logic              err
);

  localparam logic [NUM_REGS-1:0] LP_ONE = {{(NUM_REGS-1){1'b0}}, 1'b1};

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_cnt, r_rd_addr, r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_wr_en, r_err, r_load;

  logic [ADDR_W-1:0] w_cmd_addr;
  logic              w_cmd_rd, w_bad, w_ro;

  assign w_cmd_rd   = byte_data[CMD_RW_BIT];
  assign w_cmd_addr = byte_data[CMD_ADDR_MSB:0];
  assign w_bad      = 32'(w_cmd_addr) >= NUM_REGS;
  // r_cnt is always < NUM_REGS, so a one-hot select avoids an oversized index
  assign w_ro       = |(RO_MASK & (LP_ONE << r_cnt));

  // state register
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // next state; frame_end overrides everything, including a same-cycle byte
  always_comb begin
    w_next = r_state;
    if (frame_end) w_next = IDLE;
    else if (r_state == IDLE && byte_valid)
      w_next = w_bad ? ERR : (w_cmd_rd ? READ : WRITE);
  end

  // FSM outputs
  always_comb begin
    busy = (r_state != IDLE);
  end

  // datapath
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      r_cnt     <= '0;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_wr_en   <= 1'b0;
      r_err     <= 1'b0;
      r_load    <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      r_load  <= 1'b0;
      if (frame_end) begin
        r_cnt <= '0;
        r_err <= 1'b0;
      end else begin
        case (r_state)
          IDLE: if (byte_valid) begin
            if (w_bad) r_err <= 1'b1;
            else if (w_cmd_rd) begin
              r_rd_addr <= w_cmd_addr;
              r_load    <= 1'b1;
            end else r_cnt <= w_cmd_addr;
          end
          WRITE: if (byte_valid) begin
            if (w_ro) r_err <= 1'b1;
            else begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_cnt;
              r_wr_data <= byte_data;
            end
            r_cnt <= ADDR_W'(addr_wrap(32'(r_cnt), NUM_REGS));
          end
          READ: begin
            // dummy byte content is ignored; it only paces the next reload
            if (byte_valid) r_load <= 1'b1;
            if (r_load) r_rd_addr <= ADDR_W'(addr_wrap(32'(r_rd_addr), NUM_REGS));
          end
          default: ;
        endcase
      end
    end
  end

  poci_shift_reg #(.W(DATA_W)) u_poci (
    .i_sclk (sclk),
    .i_rstn (rstn),
    .i_clr  (frame_end),
    .i_load (r_load),
    .i_shift(r_state == READ),
    .i_din  (rd_data),
    .o_sout (poci)
  );

  assign rd_addr = r_rd_addr;
  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign err     = r_err;

endmodule
